ascii_msg_sequencer: RTL and testbench

Controller that walks a 16-entry ASCII message ROM and streams its characters to a consumer over a valid/ready handshake. It provides start/abort control, one-shot or looping playback, NUL-terminated messages, and a programmable inter-character gap. It sits between the fixed character ROM (combinational, address in → data out in the same cycle) and an output sink such as a UART or a parallel output port.

---
 rtl/ascii_seq_pkg.sv | 18 +
 rtl/ascii_msg_sequencer_gap_timer.sv | 41 ++++
 rtl/ascii_msg_sequencer.sv | 173 +++++++++++++++++
 tb/tb_ascii_msg_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ascii_seq_pkg.sv
// Shared types and constants for the ASCII message sequencer.
// Holds the controller state encoding and the default widths.
package ascii_seq_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_GAP_W  = 8;

    localparam logic [7:0] ASCII_NUL = 8'h00;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        GAP     = 2'd3
    } seq_state_e;

endpackage

// File: rtl/ascii_msg_sequencer_gap_timer.sv
// Loadable down-counter used to insert idle cycles between characters.
// The terminal-count flag marks the last cycle of the gap.
module gap_timer
    import ascii_seq_pkg::*;
#(
    parameter int GAP_W = DEF_GAP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [GAP_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             tc_o
);

    logic [GAP_W-1:0] cnt_q;

    // Counter register: clear wins over load, load wins over decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {GAP_W{1'b0}};
        end else if (ena_i) begin
            if (clr_i) begin
                cnt_q <= {GAP_W{1'b0}};
            end else if (load_i) begin
                cnt_q <= load_val_i;
            end else if (dec_i && (cnt_q != {GAP_W{1'b0}})) begin
                cnt_q <= cnt_q - {{(GAP_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_q <= cnt_q;
            end
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign tc_o = (cnt_q == {{(GAP_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/ascii_msg_sequencer.sv
// Walks a character ROM and streams each non-NUL entry over valid/ready,
// with optional looping and a programmable gap after each accepted character.
module ascii_msg_sequencer
    import ascii_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int GAP_W  = DEF_GAP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic              abort,
    input  logic              loop,
    input  logic [GAP_W-1:0]  gap,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] char_out,
    output logic              char_valid,
    input  logic              char_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0] char_out_q, char_out_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              emitted_q, emitted_d;
    logic              eom_s;
    logic              tmr_clr_s, tmr_load_s, tmr_dec_s, tmr_tc_s;

    gap_timer #(.GAP_W(GAP_W)) u_gap_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena_i      (ena),
        .clr_i      (tmr_clr_s),
        .load_i     (tmr_load_s),
        .load_val_i (gap),
        .dec_i      (tmr_dec_s),
        .tc_o       (tmr_tc_s)
    );

    // Next-state and output logic; end-of-message is resolved after the case.
    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        char_out_d = char_out_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
        emitted_d  = emitted_q;
        eom_s      = 1'b0;
        tmr_clr_s  = 1'b0;
        tmr_load_s = 1'b0;
        tmr_dec_s  = 1'b0;

        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            valid_d    = 1'b0;
            rom_addr_d = {ADDR_W{1'b0}};
            tmr_clr_s  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        rom_addr_d = {ADDR_W{1'b0}};
                        emitted_d  = 1'b0;
                        state_d    = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
                FETCH: begin
                    char_out_d = rom_data;
                    if (rom_data != DATA_W'(ASCII_NUL)) begin
                        valid_d = 1'b1;
                        state_d = PRESENT;
                    end else begin
                        eom_s = 1'b1;
                    end
                end
                PRESENT: begin
                    if (char_ready) begin
                        valid_d   = 1'b0;
                        emitted_d = 1'b1;
                        if (rom_addr_q == ADDR_LAST) begin
                            eom_s = 1'b1;
                        end else begin
                            rom_addr_d = rom_addr_q + ADDR_ONE;
                            if (gap != {GAP_W{1'b0}}) begin
                                tmr_load_s = 1'b1;
                                state_d    = GAP;
                            end else begin
                                state_d = FETCH;
                            end
                        end
                    end else begin
                        state_d = PRESENT;
                    end
                end
                GAP: begin
                    tmr_dec_s = 1'b1;
                    if (tmr_tc_s) begin
                        state_d = FETCH;
                    end else begin
                        state_d = GAP;
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase

            // An empty pass never loops, so a NUL at entry 0 always ends with done.
            if (eom_s) begin
                if (loop && emitted_d) begin
                    rom_addr_d = {ADDR_W{1'b0}};
                    state_d    = FETCH;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end else begin
                done_d = 1'b0;
            end
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers; ena low freezes everything including done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rom_addr_q <= {ADDR_W{1'b0}};
            char_out_q <= {DATA_W{1'b0}};
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            emitted_q  <= 1'b0;
        end else if (ena) begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            char_out_q <= char_out_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            emitted_q  <= emitted_d;
        end else begin
            state_q    <= state_q;
            rom_addr_q <= rom_addr_q;
            char_out_q <= char_out_q;
            valid_q    <= valid_q;
            busy_q     <= busy_q;
            done_q     <= done_q;
            emitted_q  <= emitted_q;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign char_out   = char_out_q;
    assign char_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_ascii_msg_sequencer.sv
// Directed bench for ascii_msg_sequencer: a bench-side ROM, a sampling
// collector and hand-derived cycle positions for each scenario.
module tb_ascii_msg_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena, start, abort, loop, char_ready;
    logic [7:0] gap;
    logic [3:0] rom_addr;
    logic [7:0] rom_data, char_out;
    logic       char_valid, busy, done;

    logic [7:0] rom [16];
    string      msg = "siliconpr0n.org";

    int n_checks = 0;
    int n_errors = 0;

    int got_chr [64];
    int got_t   [64];
    int n_got, done_cnt, done_t, drop_at;

    assign rom_data = rom[rom_addr];

    ascii_msg_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start      (start),
        .abort      (abort),
        .loop       (loop),
        .gap        (gap),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .char_out   (char_out),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_msg();
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        for (int i = 0; i < msg.len(); i++) rom[i] = msg[i];
    endtask

    // Pulse start across one edge; afterwards the DUT is in FETCH (t = 0).
    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Sample for n cycles after do_start; t counts edges since the start edge.
    task automatic run_collect(input int n);
        n_got = 0; done_cnt = 0; done_t = -1;
        for (int t = 1; t <= n; t++) begin
            step();
            if (char_valid && char_ready) begin
                got_chr[n_got] = int'(char_out);
                got_t[n_got]   = t;
                n_got++;
                if (n_got == drop_at) loop = 1'b0;
            end
            if (done) begin
                if (done_cnt == 0) done_t = t;
                done_cnt++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0; loop = 1'b0;
        gap = 8'd0; char_ready = 1'b1; drop_at = -1;
        load_msg();
        #12;
        check_eq("rst_valid", int'(char_valid), 0);
        check_eq("rst_char", int'(char_out), 0);
        check_eq("rst_addr", int'(rom_addr), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        rst_n = 1'b1;
        step();

        // One-shot playback, gap 0, always ready.
        do_start();
        check_eq("t0_valid", int'(char_valid), 0);
        check_eq("t0_busy", int'(busy), 1);
        run_collect(40);
        check_eq("os_count", n_got, 15);
        for (int i = 0; i < 15; i++) begin
            check_eq($sformatf("os_chr%0d", i), got_chr[i], int'(msg[i]));
            check_eq($sformatf("os_t%0d", i), got_t[i], 2 * i + 1);
        end
        check_eq("os_first", got_chr[0], 32'h73);
        check_eq("os_last", got_chr[14], 32'h67);
        check_eq("os_done_cnt", done_cnt, 1);
        check_eq("os_done_t", done_t, 31);
        check_eq("os_busy_end", int'(busy), 0);

        // Backpressure on the first character, then abort on the fourth.
        char_ready = 1'b0;
        do_start();
        for (int t = 1; t <= 5; t++) begin
            step();
            check_eq($sformatf("bp_valid%0d", t), int'(char_valid), 1);
            check_eq($sformatf("bp_chr%0d", t), int'(char_out), 32'h73);
        end
        char_ready = 1'b1;
        step();
        check_eq("bp_hs_valid", int'(char_valid), 0);
        step();
        check_eq("bp_next_valid", int'(char_valid), 1);
        check_eq("bp_next_chr", int'(char_out), 32'h69);
        step(); step();
        check_eq("bp_third", int'(char_out), 32'h6c);
        step(); step();
        check_eq("ab_fourth", int'(char_out), 32'h69);
        check_eq("ab_fourth_v", int'(char_valid), 1);
        abort = 1'b1;
        char_ready = 1'b0;
        step();
        abort = 1'b0;
        check_eq("ab_valid", int'(char_valid), 0);
        check_eq("ab_done", int'(done), 0);
        check_eq("ab_busy", int'(busy), 0);
        check_eq("ab_addr", int'(rom_addr), 0);
        char_ready = 1'b1;

        // Gap of 3: accepted characters 5 cycles apart.
        gap = 8'd3;
        do_start();
        run_collect(12);
        check_eq("gap_count", n_got, 3);
        check_eq("gap_t0", got_t[0], 1);
        check_eq("gap_t1", got_t[1], 6);
        check_eq("gap_t2", got_t[2], 11);
        check_eq("gap_chr2", got_chr[2], 32'h6c);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("gap_ab_busy", int'(busy), 0);

        // Asynchronous reset while in GAP.
        do_start();
        step(); step();
        check_eq("mg_busy_pre", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_eq("mg_valid", int'(char_valid), 0);
        check_eq("mg_char", int'(char_out), 0);
        check_eq("mg_addr", int'(rom_addr), 0);
        check_eq("mg_busy", int'(busy), 0);
        check_eq("mg_done", int'(done), 0);
        #2;
        rst_n = 1'b1;
        gap = 8'd0;
        step();
        do_start();
        run_collect(2);
        check_eq("fresh_chr", got_chr[0], 32'h73);
        check_eq("fresh_t", got_t[0], 1);
        abort = 1'b1;
        step();
        abort = 1'b0;

        // Looping, then drop loop partway through the second pass.
        loop = 1'b1;
        drop_at = 20;
        do_start();
        run_collect(80);
        drop_at = -1;
        check_eq("lp_count", n_got, 30);
        check_eq("lp_t14", got_t[14], 29);
        check_eq("lp_wrap_chr", got_chr[15], 32'h73);
        check_eq("lp_wrap_t", got_t[15], 32);
        check_eq("lp_last_chr", got_chr[29], 32'h67);
        check_eq("lp_done_cnt", done_cnt, 1);
        check_eq("lp_done_t", done_t, 62);
        check_eq("lp_busy_end", int'(busy), 0);

        // Empty message with loop set; ena low holds the done pulse.
        loop = 1'b1;
        rom[0] = 8'h00;
        do_start();
        step();
        check_eq("em_done", int'(done), 1);
        check_eq("em_valid", int'(char_valid), 0);
        check_eq("em_busy", int'(busy), 0);
        ena = 1'b0;
        step();
        check_eq("ena_hold_done", int'(done), 1);
        ena = 1'b1;
        step();
        check_eq("em_done_clr", int'(done), 0);
        check_eq("em_valid2", int'(char_valid), 0);
        loop = 1'b0;

        // Full ROM without NUL terminator: ends after entry 15.
        for (int i = 0; i < 16; i++) rom[i] = 8'h41 + 8'(i);
        do_start();
        run_collect(40);
        check_eq("full_count", n_got, 16);
        check_eq("full_last", got_chr[15], 32'h50);
        check_eq("full_last_t", got_t[15], 31);
        check_eq("full_done_t", done_t, 32);
        check_eq("full_done_cnt", done_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
